dc_seq: RTL and testbench



---
 rtl/dc_seq.sv | 132 +++++++++++++
 tb/tb_dc_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/dc_seq.sv
// Microsequencer for the 4-page MicROM. It holds the registered microaddress and the
// microinstruction register, and computes the next address (call/return stack, PLA, branch, trap).
module dc_seq #(
    parameter logic [8:0] RESET_VEC = 9'h100,
    parameter logic [8:0] TRAP_VEC  = 9'h1F8,
    parameter int         STK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        step,
    input  logic        ax,
    input  logic [8:0]  ma,
    input  logic [15:0] mc,
    input  logic        cond,
    input  logic [6:0]  pla,
    input  logic        trap,
    output logic [9:0]  a_out,
    output logic [15:0] mir,
    output logic        mir_vld,
    output logic        trap_ack,
    output logic        stk_err
);

    localparam int IW  = $clog2(STK_DEPTH);
    localparam int SPW = $clog2(STK_DEPTH + 1);

    typedef enum logic [1:0] {
        OP_NEXT = 2'b00,
        OP_CALL = 2'b01,
        OP_XLAT = 2'b10,
        OP_RET  = 2'b11
    } seq_op_e;

    logic [8:0]     loc_q, loc_d;
    logic           ax_q, ax_d;
    logic [15:0]    mir_q, mir_d;
    logic           mir_vld_q, mir_vld_d;
    logic           trap_ack_q, trap_ack_d;
    logic           stk_err_q, stk_err_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [8:0]     stk_q [STK_DEPTH];
    logic [8:0]     stk_d [STK_DEPTH];

    seq_op_e        op;
    logic [8:0]     br_tgt;
    logic [SPW-1:0] sp_m1;

    assign op     = seq_op_e'(mc[15:14]);
    assign br_tgt = {ma[8:1], ma[0] | (mc[13] & cond)};
    assign sp_m1  = sp_q - SPW'(1);

    always_comb begin
        loc_d      = loc_q;
        ax_d       = ax_q;
        mir_d      = mir_q;
        mir_vld_d  = mir_vld_q;
        trap_ack_d = 1'b0;
        stk_err_d  = stk_err_q;
        sp_d       = sp_q;
        stk_d      = stk_q;

        if (step) begin
            ax_d      = ax;
            mir_d     = mc;
            mir_vld_d = 1'b1;
            unique case (op)
                OP_NEXT: loc_d = br_tgt;
                OP_CALL: begin
                    loc_d = br_tgt;
                    // A full stack replaces its top entry so the next RET returns the newest call.
                    if (sp_q == SPW'(STK_DEPTH)) begin
                        stk_d[sp_m1[IW-1:0]] = mc[8:0];
                        stk_err_d            = 1'b1;
                    end else begin
                        stk_d[sp_q[IW-1:0]] = mc[8:0];
                        sp_d                = sp_q + SPW'(1);
                    end
                end
                OP_XLAT: begin
                    if (trap) begin
                        loc_d      = TRAP_VEC;
                        trap_ack_d = 1'b1;
                    end else begin
                        loc_d = {2'b00, pla};
                    end
                end
                OP_RET: begin
                    if (sp_q == '0) begin
                        loc_d     = RESET_VEC;
                        stk_err_d = 1'b1;
                    end else begin
                        loc_d = stk_q[sp_m1[IW-1:0]];
                        sp_d  = sp_m1;
                    end
                end
                default: loc_d = br_tgt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            loc_q      <= RESET_VEC;
            ax_q       <= 1'b0;
            mir_q      <= '0;
            mir_vld_q  <= 1'b0;
            trap_ack_q <= 1'b0;
            stk_err_q  <= 1'b0;
            sp_q       <= '0;
        end else begin
            loc_q      <= loc_d;
            ax_q       <= ax_d;
            mir_q      <= mir_d;
            mir_vld_q  <= mir_vld_d;
            trap_ack_q <= trap_ack_d;
            stk_err_q  <= stk_err_d;
            sp_q       <= sp_d;
        end
    end

    // Stack storage needs no reset: sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        stk_q <= stk_d;
    end

    assign a_out    = {ax_q, loc_q};
    assign mir      = mir_q;
    assign mir_vld  = mir_vld_q;
    assign trap_ack = trap_ack_q;
    assign stk_err  = stk_err_q;

endmodule

// File: tb/tb_dc_seq.sv
// Bench for dc_seq: directed scenarios plus random stimulus, all checked against
// a queue-based behavioural model of the sequencer.
module tb_dc_seq;

    localparam logic [8:0] RESET_VEC = 9'h100;
    localparam logic [8:0] TRAP_VEC  = 9'h1F8;
    localparam int         DEPTH     = 4;

    logic        clk = 1'b0;
    logic        nrst, step, ax, cond, trap;
    logic [8:0]  ma;
    logic [15:0] mc;
    logic [6:0]  pla;
    logic [9:0]  a_out;
    logic [15:0] mir;
    logic        mir_vld, trap_ack, stk_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  m_loc;
    logic        m_ax;
    logic [15:0] m_mir;
    logic        m_vld, m_ack, m_err;
    logic [8:0]  m_stk[$];

    dc_seq #(.RESET_VEC(RESET_VEC), .TRAP_VEC(TRAP_VEC), .STK_DEPTH(DEPTH)) dut (
        .clk(clk), .nrst(nrst), .step(step), .ax(ax), .ma(ma), .mc(mc),
        .cond(cond), .pla(pla), .trap(trap), .a_out(a_out), .mir(mir),
        .mir_vld(mir_vld), .trap_ack(trap_ack), .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour of one clock edge, applied with the inputs present at that edge.
    task automatic model_edge();
        logic [8:0] nxt;
        logic       ack;
        if (!nrst) begin
            m_loc = RESET_VEC; m_ax = 1'b0; m_mir = '0;
            m_vld = 1'b0; m_ack = 1'b0; m_err = 1'b0;
            m_stk.delete();
        end else if (!step) begin
            m_ack = 1'b0;
        end else begin
            ack = 1'b0;
            nxt = mc[13] ? {ma[8:1], ma[0] | cond} : ma;
            case (mc[15:14])
                2'b01: begin
                    if (m_stk.size() == DEPTH) begin
                        m_stk[DEPTH-1] = mc[8:0];
                        m_err = 1'b1;
                    end else begin
                        m_stk.push_back(mc[8:0]);
                    end
                end
                2'b10: begin
                    if (trap) begin nxt = TRAP_VEC; ack = 1'b1; end
                    else nxt = {2'b00, pla};
                end
                2'b11: begin
                    if (m_stk.size() == 0) begin nxt = RESET_VEC; m_err = 1'b1; end
                    else nxt = m_stk.pop_back();
                end
                default: ;
            endcase
            m_loc = nxt; m_ax = ax; m_mir = mc; m_vld = 1'b1; m_ack = ack;
        end
    endtask

    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".a_out"},    16'(a_out),    16'({m_ax, m_loc}));
        check({tag, ".mir"},      mir,           m_mir);
        check({tag, ".mir_vld"},  16'(mir_vld),  16'(m_vld));
        check({tag, ".trap_ack"}, 16'(trap_ack), 16'(m_ack));
        check({tag, ".stk_err"},  16'(stk_err),  16'(m_err));
    endtask

    task automatic drive(input logic [15:0] c, input logic [8:0] a);
        mc = c; ma = a; step = 1'b1;
    endtask

    task automatic do_reset();
        nrst = 1'b0; step = 1'b0;
        cyc("reset");
        cyc("reset");
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0; step = 1'b0; ax = 1'b0; cond = 1'b0; trap = 1'b0;
        ma = '0; mc = '0; pla = '0;

        // Reset and first fetch
        do_reset();
        check("rst.a_out", 16'(a_out), 16'h100);
        check("rst.vld", 16'(mir_vld), 16'h0);
        drive(16'h0055, 9'h104);
        cyc("first");
        check("first.a_out", 16'(a_out), 16'h104);
        check("first.mir", mir, 16'h0055);

        // Stall with changing ROM outputs
        step = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mc = 16'($urandom); ma = 9'($urandom);
            cyc("stall");
        end
        check("stall.a_out", 16'(a_out), 16'h104);

        // Call / return
        drive(16'h4020, 9'h180); cyc("call");
        check("call.a_out", 16'(a_out), 16'h180);
        drive(16'h0000, 9'h0A4); cyc("call_next");
        drive(16'hC000, 9'h000); cyc("ret");
        check("ret.a_out", 16'(a_out), 16'h020);
        check("ret.err", 16'(stk_err), 16'h0);
        drive(16'hC000, 9'h000); cyc("ret_empty");
        check("ret_empty.a_out", 16'(a_out), 16'h100);
        check("ret_empty.err", 16'(stk_err), 16'h1);

        // Overflow
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(16'h4010 + 16'(i), 9'h180); cyc("ovf_call");
        end
        check("ovf.err", 16'(stk_err), 16'h1);
        drive(16'hC000, 9'h000); cyc("ovf_ret");
        check("ovf_ret.a_out", 16'(a_out), 16'h014);

        // Underflow from reset
        do_reset();
        drive(16'hC000, 9'h055); cyc("unf");
        check("unf.a_out", 16'(a_out), 16'h100);
        check("unf.err", 16'(stk_err), 16'h1);

        // Translate and trap
        pla = 7'h2A; trap = 1'b0;
        drive(16'h8000, 9'h033); cyc("xlat");
        check("xlat.a_out", 16'(a_out), 16'h02A);
        trap = 1'b1;
        drive(16'h8000, 9'h033); cyc("trap");
        check("trap.a_out", 16'(a_out), 16'h1F8);
        check("trap.ack", 16'(trap_ack), 16'h1);
        drive(16'h0000, 9'h050); cyc("trap_next");
        check("trap_next.a_out", 16'(a_out), 16'h050);
        check("trap_next.ack", 16'(trap_ack), 16'h0);
        trap = 1'b0;

        // Branch and AX
        cond = 1'b1; drive(16'h2000, 9'h0C0); cyc("br1");
        check("br1.a_out", 16'(a_out), 16'h0C1);
        cond = 1'b0; drive(16'h2000, 9'h0C0); cyc("br0");
        check("br0.a_out", 16'(a_out), 16'h0C0);
        ax = 1'b1; drive(16'h0000, 9'h044); cyc("ax");
        check("ax.a_out", 16'(a_out), 16'h244);
        ax = 1'b0;

        // Random stimulus
        for (int i = 0; i < 600; i++) begin
            nrst = ($urandom_range(0, 59) != 0);
            step = ($urandom_range(0, 3) != 0);
            ax   = 1'($urandom);
            cond = 1'($urandom);
            trap = ($urandom_range(0, 2) == 0);
            ma   = 9'($urandom);
            mc   = 16'($urandom);
            pla  = 7'($urandom);
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
